mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have one parameter: FAIR, default 1, 1 = round-robin arbitration, 0 = fixed priority with requester 0 winning.
REQ-002 The block SHALL have these ports, one per line:
- clk  input  1  sole clock; all state updates on its rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req0  input  1  requester 0 wants a product
- a0  input  3  requester 0 multiplicand
- b0  input  3  requester 0 multiplier
- gnt0  output  1  one-cycle pulse: requester 0 operands captured
- req1  input  1  requester 1 wants a product
- a1  input  3  requester 1 multiplicand
- b1  input  3  requester 1 multiplier
- gnt1  output  1  one-cycle pulse: requester 1 operands captured
- p  output  6  registered unsigned product
- p_valid  output  1  p and p_id are valid
- p_id  output  1  requester that owns p (0 or 1)
- p_ack  input  1  consumer accepts p
- busy  output  1  high whenever state is not IDLE

Function
REQ-003 The block SHALL contain exactly one instance of the team's 3x3 combinational array multiplier, fed only from internal operand registers op_a[2:0] and op_b[2:0].
REQ-004 The state machine SHALL have three states: IDLE, MUL and RESP.
REQ-005 In IDLE with neither request high, the state SHALL stay IDLE and all outputs SHALL hold their values.
REQ-006 In IDLE with at least one request high at a rising edge, the block SHALL:
- select a winner per REQ-009
- load op_a/op_b from the winner's operands
- record the winner in sel
- assert the winner's gnt for exactly the following cycle
- move to MUL
REQ-007 In MUL, the next edge SHALL:
- register the multiplier output into p
- drive p_id from sel
- set p_valid to 1
- move to RESP
- gnt0 and gnt1 are 0 from this point on.
REQ-008 In RESP, p, p_id and p_valid SHALL hold until p_ack is sampled high; on that edge p_valid clears to 0 and the state moves to IDLE.
REQ-009 Arbitration SHALL work as follows:
- If only one request is high, that requester wins.
- If both are high and FAIR=1, the requester not recorded in last_served wins.
- If both are high and FAIR=0, requester 0 wins.
- last_served updates to the winner on every grant.
REQ-010 Latency SHALL be fixed: request sampled at edge N -> gnt high during cycle N..N+1 -> p_valid high from edge N+1; minimum issue interval is 3 cycles with p_ack held high.
REQ-011 p SHALL be the exact unsigned product, range 0..49; no overflow is possible in 6 bits.
REQ-012 Operand and request changes after the capture edge SHALL NOT affect the operation in flight.
REQ-013 A requester SHALL deassert req in the cycle it sees gnt; a request still high when the block returns to IDLE is served again as a new operation.
REQ-014 p_ack while p_valid=0 SHALL be ignored.
REQ-015 A request arriving during MUL or RESP SHALL not be granted until the block is back in IDLE; it is not lost as long as req stays high.
REQ-016 busy SHALL be 1 in MUL and RESP and 0 in IDLE.

Reset
REQ-017 While rst_n=0, regardless of clk, the block SHALL force:
- state=IDLE
- p=0, p_valid=0, p_id=0
- gnt0=0, gnt1=0, busy=0
- op_a=0, op_b=0, sel=0
- last_served=1, so requester 0 wins the first tie
REQ-018 Reset asserted mid-operation (MUL or RESP) SHALL discard the operation with no p_valid pulse; after rst_n rises, the first rising edge is evaluated as IDLE.

Verification
REQ-019 req0=1, a0=3, b0=5, p_ack=1 held -> gnt0 one cycle, then p=15, p_id=0, p_valid high for one cycle, busy high for 2 cycles.
REQ-020 Exhaustive test on requester 1, all 64 (a1,b1) pairs -> every p equals a1*b1, including 7*7=49 and 0*x=0, with p_id=1.
REQ-021 FAIR=1, req0 and req1 both held high, a0=2,b0=3, a1=4,b1=5, p_ack=1 -> results alternate 6 (id 0), 20 (id 1), 6, 20; with FAIR=0 -> always 6 (id 0) while req0 stays high.
REQ-022 Grant with p_ack held low for 10 cycles -> p, p_id and p_valid stable for all 10 cycles; operands changed after gnt do not alter p; p_ack high -> p_valid low on the next edge.
REQ-023 rst_n pulled low asynchronously while in RESP with p=35 -> p=0, p_valid=0 and busy=0 immediately, without waiting for a clock edge; after release, req1 with a1=1,b1=1 -> p=1, p_id=1.

Source files
------------

// File: rtl/mult_arbiter.sv
// ============================================================================
//  Module      : mult_arbiter (with helper mult3x3)
//  Description : Two-requester arbiter sharing one 3x3 unsigned array
//                multiplier. A grant captures the winner's operands, the
//                product is registered one cycle later and held until it is
//                acknowledged.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// 3x3 combinational array multiplier: sum of AND-gated, shifted operand rows.
// ----------------------------------------------------------------------------
module mult3x3 (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [5:0] prod
);

    logic [2:0] row0;
    logic [2:0] row1;
    logic [2:0] row2;

    // Partial-product rows and their shifted sum.
    always_comb begin
        row0 = a & {3{b[0]}};
        row1 = a & {3{b[1]}};
        row2 = a & {3{b[2]}};
        prod = {3'b000, row0} + {2'b00, row1, 1'b0} + {1'b0, row2, 2'b00};
    end

endmodule

// ----------------------------------------------------------------------------
// Arbiter top level.
// ----------------------------------------------------------------------------
module mult_arbiter #(
    parameter int FAIR = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [2:0] a0,
    input  logic [2:0] b0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [2:0] a1,
    input  logic [2:0] b1,
    output logic       gnt1,
    output logic [5:0] p,
    output logic       p_valid,
    output logic       p_id,
    input  logic       p_ack,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [2:0] op_a;
    logic [2:0] op_b;
    logic       sel;
    logic       last_served;
    logic       any_req;
    logic       winner;
    logic [5:0] product;

    // The multiplier only ever sees the captured operands, so input changes
    // after the grant cannot disturb the operation in flight.
    mult3x3 u_mult (
        .a    (op_a),
        .b    (op_b),
        .prod (product)
    );

    // Winner selection: a lone request wins; a tie goes to the requester not
    // served last (round-robin) or always to requester 0 (fixed priority).
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            winner = (FAIR != 0) ? ~last_served : 1'b0;
        end else begin
            winner = req1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = MUL;
            MUL:     state_next = RESP;
            RESP:    if (p_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output registers: capture on grant, compute, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a        <= 3'd0;
            op_b        <= 3'd0;
            sel         <= 1'b0;
            last_served <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            p           <= 6'd0;
            p_valid     <= 1'b0;
            p_id        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_a        <= winner ? a1 : a0;
                        op_b        <= winner ? b1 : b0;
                        sel         <= winner;
                        last_served <= winner;
                        gnt0        <= ~winner;
                        gnt1        <= winner;
                    end
                end
                MUL: begin
                    p       <= product;
                    p_id    <= sel;
                    p_valid <= 1'b1;
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                end
                RESP: begin
                    if (p_ack) begin
                        p_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
// ============================================================================
//  Module      : tb_mult_arbiter
//  Description : Self-checking bench for mult_arbiter; one round-robin and
//                one fixed-priority instance share the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, p_ack;
    logic [2:0] a0, b0, a1, b1;

    logic       gnt0_f, gnt1_f, p_valid_f, p_id_f, busy_f;
    logic [5:0] p_f;
    logic       gnt0_x, gnt1_x, p_valid_x, p_id_x, busy_x;
    logic [5:0] p_x;

    logic [10:0] o_f;
    logic [10:0] o_x;
    assign o_f = {p_f, p_valid_f, p_id_f, gnt0_f, gnt1_f, busy_f};
    assign o_x = {p_x, p_valid_x, p_id_x, gnt0_x, gnt1_x, busy_x};

    always #5 clk = ~clk;

    mult_arbiter #(.FAIR(1)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0_f),
        .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1_f),
        .p(p_f), .p_valid(p_valid_f), .p_id(p_id_f), .p_ack(p_ack), .busy(busy_f)
    );

    mult_arbiter #(.FAIR(0)) dut_x (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0_x),
        .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1_x),
        .p(p_x), .p_valid(p_valid_x), .p_id(p_id_x), .p_ack(p_ack), .busy(busy_x)
    );

    int errors = 0;
    int checks = 0;

    // Transaction-level reference: phase 0 waiting, 1 computing, 2 presenting.
    typedef struct {
        int phase; int p; int pv; int pid; int g0; int g1;
        int last; int ca; int cb; int w;
    } mdl_t;

    mdl_t m_f, m_x;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.phase = 0; m.p = 0; m.pv = 0; m.pid = 0; m.g0 = 0; m.g1 = 0;
        m.last = 1; m.ca = 0; m.cb = 0; m.w = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit fair, bit r0, bit r1,
                                      int xa0, int xb0, int xa1, int xb1, bit ack);
        mdl_t n = m;
        if (m.phase == 0) begin
            if (r0 || r1) begin
                if (r0 && r1) n.w = fair ? (1 - m.last) : 0;
                else          n.w = r1 ? 1 : 0;
                n.ca    = (n.w == 1) ? xa1 : xa0;
                n.cb    = (n.w == 1) ? xb1 : xb0;
                n.g0    = (n.w == 0) ? 1 : 0;
                n.g1    = (n.w == 1) ? 1 : 0;
                n.last  = n.w;
                n.phase = 1;
            end
        end else if (m.phase == 1) begin
            n.p = m.ca * m.cb; n.pid = m.w; n.pv = 1;
            n.g0 = 0; n.g1 = 0; n.phase = 2;
        end else if (ack) begin
            n.pv = 0; n.phase = 0;
        end
        return n;
    endfunction

    function automatic logic [10:0] mdl_out(mdl_t m);
        return {m.p[5:0], m.pv[0], m.pid[0], m.g0[0], m.g1[0], (m.phase != 0)};
    endfunction

    task automatic cmp(string name, logic [10:0] act, logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual p=%0d valid=%0b id=%0b gnt0=%0b gnt1=%0b busy=%0b, required p=%0d valid=%0b id=%0b gnt0=%0b gnt1=%0b busy=%0b",
                     name, act[10:5], act[4], act[3], act[2], act[1], act[0],
                     exp[10:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic cmp_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    // One clock: advance the models on the rising edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            m_f = mdl_step(m_f, 1'b1, req0, req1, a0, b0, a1, b1, p_ack);
            m_x = mdl_step(m_x, 1'b0, req0, req1, a0, b0, a1, b1, p_ack);
        end else begin
            m_f = mdl_reset();
            m_x = mdl_reset();
        end
        @(negedge clk);
        cmp("model_fair", o_f, mdl_out(m_f));
        cmp("model_fixed", o_x, mdl_out(m_x));
    endtask

    typedef struct {
        logic       r0; logic [2:0] va0; logic [2:0] vb0;
        logic       r1; logic [2:0] va1; logic [2:0] vb1;
        logic       ack;
        logic [10:0] exp_f;   // {p, valid, id, gnt0, gnt1, busy} of round-robin instance
        logic [6:0]  exp_x;   // {p, id} of fixed-priority instance
    } vec_t;

    function automatic vec_t mkv(bit r0, int xa0, int xb0, bit r1, int xa1, int xb1, bit ack,
                                 int ep, bit ev, bit eid, bit eg0, bit eg1, bit eb,
                                 int xp, bit xid);
        vec_t v;
        v.r0 = r0; v.va0 = xa0[2:0]; v.vb0 = xb0[2:0];
        v.r1 = r1; v.va1 = xa1[2:0]; v.vb1 = xb1[2:0];
        v.ack = ack;
        v.exp_f = {ep[5:0], ev, eid, eg0, eg1, eb};
        v.exp_x = {xp[5:0], xid};
        return v;
    endfunction

    initial begin
        vec_t tbl[$];

        // Tie with both requests held: round-robin alternates 6/20, fixed stays 6.
        tbl.push_back(mkv(1,2,3, 1,4,5, 1,   0,0,0,1,0,1,  0,0));
        tbl.push_back(mkv(1,2,3, 1,4,5, 1,   6,1,0,0,0,1,  6,0));
        tbl.push_back(mkv(1,2,3, 1,4,5, 1,   6,0,0,0,0,0,  6,0));
        tbl.push_back(mkv(1,2,3, 1,4,5, 1,   6,0,0,0,1,1,  6,0));
        tbl.push_back(mkv(1,2,3, 1,4,5, 1,  20,1,1,0,0,1,  6,0));
        tbl.push_back(mkv(1,2,3, 1,4,5, 1,  20,0,1,0,0,0,  6,0));
        tbl.push_back(mkv(1,2,3, 1,4,5, 1,  20,0,1,1,0,1,  6,0));
        tbl.push_back(mkv(1,2,3, 1,4,5, 1,   6,1,0,0,0,1,  6,0));
        tbl.push_back(mkv(1,2,3, 1,4,5, 1,   6,0,0,0,0,0,  6,0));
        tbl.push_back(mkv(1,2,3, 1,4,5, 1,   6,0,0,0,1,1,  6,0));
        tbl.push_back(mkv(1,2,3, 1,4,5, 1,  20,1,1,0,0,1,  6,0));
        tbl.push_back(mkv(1,2,3, 1,4,5, 1,  20,0,1,0,0,0,  6,0));
        // Single request 3*5, ack held: one-cycle grant, one-cycle valid, two busy cycles.
        tbl.push_back(mkv(1,3,5, 0,0,0, 1,  20,0,1,1,0,1,  6,0));
        tbl.push_back(mkv(0,3,5, 0,0,0, 1,  15,1,0,0,0,1, 15,0));
        tbl.push_back(mkv(0,3,5, 0,0,0, 1,  15,0,0,0,0,0, 15,0));
        // Idle holds outputs; a stray ack while nothing is valid is ignored.
        tbl.push_back(mkv(0,0,0, 0,0,0, 0,  15,0,0,0,0,0, 15,0));
        tbl.push_back(mkv(0,0,0, 0,0,0, 1,  15,0,0,0,0,0, 15,0));

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; p_ack = 1'b0;
        a0 = 3'd0; b0 = 3'd0; a1 = 3'd0; b1 = 3'd0;
        m_f = mdl_reset();
        m_x = mdl_reset();
        repeat (2) @(negedge clk);
        cmp("reset_fair", o_f, 11'd0);
        cmp("reset_fixed", o_x, 11'd0);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            req0 = tbl[i].r0; a0 = tbl[i].va0; b0 = tbl[i].vb0;
            req1 = tbl[i].r1; a1 = tbl[i].va1; b1 = tbl[i].vb1;
            p_ack = tbl[i].ack;
            tick();
            cmp($sformatf("vec%0d_fair", i), o_f, tbl[i].exp_f);
            cmp_int($sformatf("vec%0d_fixed_p_id", i), int'({p_x, p_id_x}), int'(tbl[i].exp_x));
        end

        // Held result with ack low; operands change after grant; late request waits.
        req0 = 1'b0; req1 = 1'b1; a1 = 3'd6; b1 = 3'd5; p_ack = 1'b0;
        tick();
        cmp_int("hold_gnt1", int'(gnt1_f), 1);
        req1 = 1'b0; a1 = 3'd7; b1 = 3'd7;
        tick();
        for (int k = 0; k < 10; k++) begin
            if (k == 7) begin
                req0 = 1'b1; a0 = 3'd2; b0 = 3'd2;
            end
            tick();
            cmp_int($sformatf("hold%0d", k), int'({p_f, p_valid_f, p_id_f}), (30 << 2) | 3);
            cmp_int($sformatf("hold%0d_nognt", k), int'({gnt0_f, gnt1_f}), 0);
        end
        p_ack = 1'b1;
        tick();
        cmp_int("ack_clears_valid", int'(p_valid_f), 0);
        tick();
        cmp_int("late_req_granted", int'(gnt0_f), 1);
        req0 = 1'b0;
        tick();
        cmp_int("late_req_product", int'(p_f), 4);
        tick();

        // Exhaustive operands on requester 1.
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                req1 = 1'b1; a1 = x[2:0]; b1 = y[2:0]; p_ack = 1'b1;
                tick();
                req1 = 1'b0;
                tick();
                cmp_int($sformatf("exh_%0dx%0d", x, y), int'({p_f, p_id_f}), (x * y) * 2 + 1);
                tick();
            end
        end

        // Asynchronous reset while presenting 35.
        req0 = 1'b1; a0 = 3'd5; b0 = 3'd7; p_ack = 1'b0;
        tick();
        req0 = 1'b0;
        tick();
        cmp_int("pre_reset_p", int'(p_f), 35);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_reset_fair", o_f, 11'd0);
        cmp("async_reset_fixed", o_x, 11'd0);
        m_f = mdl_reset();
        m_x = mdl_reset();
        tick();
        tick();
        rst_n = 1'b1;
        req1 = 1'b1; a1 = 3'd1; b1 = 3'd1; p_ack = 1'b1;
        tick();
        req1 = 1'b0;
        tick();
        cmp_int("post_reset_p_id", int'({p_f, p_id_f}), 3);
        tick();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            req0  = 1'($urandom_range(0, 1));
            req1  = 1'($urandom_range(0, 1));
            a0    = 3'($urandom_range(0, 7));
            b0    = 3'($urandom_range(0, 7));
            a1    = 3'($urandom_range(0, 7));
            b1    = 3'($urandom_range(0, 7));
            p_ack = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
